softmc_rdback_tx: RTL
=====================

// Module: softmc_rdback_tx
// PURPOSE
// - Downstream readback stage of the SoftMC PCIe app: drains DRAM readback entries from the rdback FIFO
//   and streams them to the host over the RIFFA TX channel as one transaction per request.
// - Each DQ_WIDTH*4-bit entry is serialised into C_PCI_DATA_WIDTH-bit beats, least-significant slice first.
// PARAMETERS
// - C_PCI_DATA_WIDTH  32  RIFFA data width (32/64/128); must divide DQ_WIDTH*4.
// - DQ_WIDTH          64  DRAM DQ width; one readback entry = DQ_WIDTH*4 bits.
// PORTS
// - clk                 in   1     single clock domain (also driven onto CHNL_TX_CLK)
// - rst                 in   1     asynchronous, active-high reset
// - tx_req              in   1     one-cycle pulse: start transaction of tx_entries entries
// - tx_entries          in   16    entry count, sampled when tx_req accepted
// - tx_busy             out  1     high from accepted tx_req until tx_done
// - tx_done             out  1     one-cycle pulse at end of transaction
// - rdback_fifo_empty   in   1     readback FIFO empty
// - rdback_fifo_rden    out  1     FIFO read strobe; data valid on rdback_data the following cycle
// - rdback_data         in   DQ_WIDTH*4  FIFO read data
// - CHNL_TX_CLK         out  1     = clk
// - CHNL_TX             out  1     transaction active
// - CHNL_TX_ACK         in   1     host accepted transaction
// - CHNL_TX_LAST        out  1     constant 1
// - CHNL_TX_LEN         out  32    length in 32-bit words = entries*(DQ_WIDTH*4/32)
// - CHNL_TX_OFF         out  31    constant 0
// - CHNL_TX_DATA        out  C_PCI_DATA_WIDTH  current beat
// - CHNL_TX_DATA_VALID  out  1     beat valid
// - CHNL_TX_DATA_REN    in   1     host consumes beat when REN & VALID
// BEHAVIOUR
// - Reset (async, rst=1): state IDLE; all outputs 0 except CHNL_TX_LAST=1, CHNL_TX_CLK=clk; shift reg,
//   counters cleared. Reset mid-transfer aborts; any entry already read from FIFO is discarded.
// - BEATS = DQ_WIDTH*4/C_PCI_DATA_WIDTH; WPE (words/entry) = DQ_WIDTH*4/32. LEN = tx_entries*WPE, 32-bit,
//   computed at accept and held registered for the whole transaction.
// - States:
//   IDLE : tx_req & tx_entries!=0 -> latch count/LEN, tx_busy=1, go REQ next cycle.
//          tx_req & tx_entries==0 -> tx_done pulse next cycle, no RIFFA activity, stay IDLE.
//   REQ  : CHNL_TX=1 (held through SEND); wait CHNL_TX_ACK -> FETCH. No DATA_VALID before ACK.
//   FETCH: rdback_fifo_rden=1 for exactly one cycle when !rdback_fifo_empty -> LOAD; empty -> wait.
//   LOAD : capture rdback_data into shift reg, beat counter=0 -> SEND.
//   SEND : DATA_VALID=1, DATA=shift reg[C_PCI_DATA_WIDTH-1:0]; on REN&VALID shift right by
//          C_PCI_DATA_WIDTH, beat++. REN low -> DATA/VALID held stable.
//          last beat accepted: entries left -> FETCH; none -> DONE (CHNL_TX, VALID drop next cycle).
//   DONE : tx_done=1 one cycle, tx_busy=0 -> IDLE.
// - tx_req while tx_busy ignored (not queued). rden never asserted when rdback_fifo_empty=1.
// - Latency: tx_req -> CHNL_TX high 1 cycle; ACK -> first VALID >= 3 cycles (FETCH, LOAD, SEND).
// - Entry counter 16-bit down-counter, no wrap: 0xFFFF entries legal (LEN = 0xFFFF*WPE).
// STRUCTURE
// - Shared package softmc_pkg: state encoding enum, function words_per_entry(DQ_WIDTH).
// - One sub-module natural: softmc_entry_serializer (load/shift/beat-count of one entry, REN/VALID
//   handshake); FSM and RIFFA channel signalling stay in top.
// TESTING (DQ_WIDTH=64, C_PCI_DATA_WIDTH=32 -> 8 beats/entry unless noted)
// - tx_req, entries=1, FIFO holds 256'h..07_06_05_04_03_02_01_00 (32-bit words 0..7), REN=1
//   -> CHNL_TX_LEN=8, beats 0..7 in order, tx_done once, CHNL_TX low after beat 7.
// - entries=3, FIFO empty for 20 cycles after ACK then 3 entries arrive -> no VALID/rden while empty,
//   24 beats, exactly 3 rden pulses.
// - REN random 50% toggling -> DATA stable while VALID&!REN; no beat lost or duplicated.
// - entries=0 -> tx_done next cycle, CHNL_TX never asserted; tx_req during busy -> ignored.
// - C_PCI_DATA_WIDTH=128, entries=2 -> LEN=16, 4 beats of 128 bits, low slice first.
// - rst asserted mid-SEND (beat 4) -> all outputs 0 same cycle; next tx_req starts clean transaction.

Source files
------------

// File: rtl/softmc_pkg.sv
// Shared definitions for the SoftMC readback TX path: FSM state encoding and
// the entry-to-RIFFA-word sizing helper.
package softmc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_FETCH,
        ST_LOAD,
        ST_SEND,
        ST_DONE
    } tx_state_e;

    localparam int unsigned RIFFA_WORD_W = 32;

    // One readback entry is four DQ-wide bursts; RIFFA counts in 32-bit words.
    function automatic int unsigned words_per_entry(input int unsigned dq_width);
        return (dq_width * 4) / RIFFA_WORD_W;
    endfunction

endpackage

// File: rtl/softmc_entry_serializer.sv
// Holds one readback entry and hands it out as DATA_W-bit beats, low slice first,
// under a VALID/REN handshake. last_accept flags the handshake of the final beat.
module softmc_entry_serializer #(
    parameter int DATA_W  = 32,
    parameter int ENTRY_W = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [ENTRY_W-1:0] load_data,
    input  logic               ren,
    output logic [DATA_W-1:0]  data,
    output logic               valid,
    output logic               last_accept
);

    localparam int BEATS = ENTRY_W / DATA_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [ENTRY_W-1:0] shift_reg;
    logic [CNT_W-1:0]   beat_cnt;
    logic               accept;

    assign accept      = valid & ren;
    assign last_accept = accept && (beat_cnt == CNT_W'(BEATS - 1));
    assign data        = shift_reg[DATA_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            beat_cnt  <= '0;
            valid     <= 1'b0;
        end else if (load) begin
            shift_reg <= load_data;
            beat_cnt  <= '0;
            valid     <= 1'b1;
        end else if (accept) begin
            // With REN low nothing here moves, so DATA/VALID stay put for the host.
            shift_reg <= shift_reg >> DATA_W;
            beat_cnt  <= beat_cnt + CNT_W'(1);
            if (last_accept)
                valid <= 1'b0;
        end
    end

endmodule

// File: rtl/softmc_rdback_tx.sv
// Drains DRAM readback entries from the rdback FIFO and sends them to the host
// as a single RIFFA TX transaction per tx_req.
module softmc_rdback_tx
    import softmc_pkg::*;
#(
    parameter int C_PCI_DATA_WIDTH = 32,
    parameter int DQ_WIDTH         = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tx_req,
    input  logic [15:0]                 tx_entries,
    output logic                        tx_busy,
    output logic                        tx_done,
    input  logic                        rdback_fifo_empty,
    output logic                        rdback_fifo_rden,
    input  logic [DQ_WIDTH*4-1:0]       rdback_data,
    output logic                        CHNL_TX_CLK,
    output logic                        CHNL_TX,
    input  logic                        CHNL_TX_ACK,
    output logic                        CHNL_TX_LAST,
    output logic [31:0]                 CHNL_TX_LEN,
    output logic [30:0]                 CHNL_TX_OFF,
    output logic [C_PCI_DATA_WIDTH-1:0] CHNL_TX_DATA,
    output logic                        CHNL_TX_DATA_VALID,
    input  logic                        CHNL_TX_DATA_REN
);

    localparam int          ENTRY_W = DQ_WIDTH * 4;
    localparam logic [31:0] WPE     = 32'(words_per_entry(DQ_WIDTH));

    tx_state_e   state;
    logic [15:0] entries_left;
    logic        load;
    logic        last_accept;

    assign CHNL_TX_CLK  = clk;
    assign CHNL_TX_LAST = 1'b1;
    assign CHNL_TX_OFF  = '0;

    // Gating with empty here keeps the strobe off an empty FIFO in the same cycle.
    assign rdback_fifo_rden = (state == ST_FETCH) && !rdback_fifo_empty;
    assign load             = (state == ST_LOAD);

    softmc_entry_serializer #(
        .DATA_W  (C_PCI_DATA_WIDTH),
        .ENTRY_W (ENTRY_W)
    ) u_serializer (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .load_data   (rdback_data),
        .ren         (CHNL_TX_DATA_REN),
        .data        (CHNL_TX_DATA),
        .valid       (CHNL_TX_DATA_VALID),
        .last_accept (last_accept)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            entries_left <= '0;
            CHNL_TX_LEN  <= '0;
            CHNL_TX      <= 1'b0;
            tx_busy      <= 1'b0;
            tx_done      <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tx_req) begin
                        if (tx_entries != 16'd0) begin
                            entries_left <= tx_entries;
                            CHNL_TX_LEN  <= {16'd0, tx_entries} * WPE;
                            tx_busy      <= 1'b1;
                            CHNL_TX      <= 1'b1;
                            state        <= ST_REQ;
                        end else begin
                            // Empty request completes immediately without touching RIFFA.
                            tx_done <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (CHNL_TX_ACK)
                        state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (!rdback_fifo_empty)
                        state <= ST_LOAD;
                end
                ST_LOAD: begin
                    state <= ST_SEND;
                end
                ST_SEND: begin
                    if (last_accept) begin
                        entries_left <= entries_left - 16'd1;
                        if (entries_left == 16'd1) begin
                            CHNL_TX <= 1'b0;
                            tx_busy <= 1'b0;
                            tx_done <= 1'b1;
                            state   <= ST_DONE;
                        end else begin
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
